// File: rtl/frame_receiver_if.sv
// MAC receive-side bundle: the byte stream and status pulses from the MAC, and the MAC's
// receive configuration straps.
`timescale 1ns/1ps
interface frame_receiver_if;
  logic       conf_rx_en;
  logic       conf_rx_jumbo_en;
  logic       conf_rx_no_chk_crc;
  logic [7:0] mac_rx_data;
  logic       mac_rx_dvld;
  logic       mac_rx_goodframe;
  logic       mac_rx_badframe;

  modport master (
    output mac_rx_data, mac_rx_dvld, mac_rx_goodframe, mac_rx_badframe,
    input  conf_rx_en, conf_rx_jumbo_en, conf_rx_no_chk_crc
  );

  modport slave (
    input  mac_rx_data, mac_rx_dvld, mac_rx_goodframe, mac_rx_badframe,
    output conf_rx_en, conf_rx_jumbo_en, conf_rx_no_chk_crc
  );
endinterface

// File: rtl/frame_receiver.sv
// Ethernet frame filter: accepts broadcast/unicast frames of one EtherType, tracks MAC status,
// counts accepted frames and measures the delay from a local transmit start to the match.
`timescale 1ns/1ps
module frame_receiver #(
  parameter logic [47:0] MY_MAC_ADDR     = 48'h004e46324301,
  parameter logic [15:0] ETH_TYPE_FILTER = 16'h0806,
  parameter int unsigned MIN_LEN         = 60,
  parameter int unsigned MAX_LEN         = 1518,
  parameter int unsigned STATUS_TIMEOUT  = 16
) (
  input  logic            not_tx_clk,
  input  logic            reset,
  frame_receiver_if.slave mac,
  input  logic            tx_start,
  output logic            frame_match,
  output logic            frame_err,
  output logic [31:0]     delay_count,
  output logic            delay_valid,
  output logic [15:0]     rx_frame_cnt
);

  localparam int unsigned WaitW      = $clog2(STATUS_TIMEOUT + 1);
  localparam logic [10:0] MaxCnt     = 11'(MAX_LEN);
  localparam logic [10:0] MinCnt     = 11'(MIN_LEN);
  localparam logic [WaitW-1:0] TimeoutCnt = WaitW'(STATUS_TIMEOUT - 1);

  typedef enum logic [2:0] {
    StIdle, StDst, StSrc, StType, StPayload, StWaitStatus, StDrop
  } state_e;

  state_e           state_q;
  logic [10:0]      byte_cnt_q;
  logic             drop_q;
  logic             bc_ok_q;
  logic             uc_ok_q;
  logic             resync_q;
  logic [WaitW-1:0] wait_cnt_q;
  logic             armed_q;
  logic [31:0]      timer_q;

  logic [10:0] byte_num;
  logic [7:0]  mac_byte;
  logic [7:0]  type_byte;
  logic        bc_next;
  logic        uc_next;
  logic        in_frame;
  logic        start_frame;
  logic        status_seen;
  logic        good;
  logic        match_now;
  logic        err_now;
  logic        status_cycle;
  logic        match_fire;
  logic [31:0] timer_inc;

  always_comb begin
    byte_num = (state_q == StIdle || state_q == StWaitStatus) ? 11'd1 : byte_cnt_q + 11'd1;
    case (byte_num)
      11'd1:   mac_byte = MY_MAC_ADDR[47:40];
      11'd2:   mac_byte = MY_MAC_ADDR[39:32];
      11'd3:   mac_byte = MY_MAC_ADDR[31:24];
      11'd4:   mac_byte = MY_MAC_ADDR[23:16];
      11'd5:   mac_byte = MY_MAC_ADDR[15:8];
      11'd6:   mac_byte = MY_MAC_ADDR[7:0];
      default: mac_byte = 8'h00;
    endcase
    type_byte = (byte_num == 11'd13) ? ETH_TYPE_FILTER[15:8] : ETH_TYPE_FILTER[7:0];
    bc_next   = ((byte_num == 11'd1) || bc_ok_q) && (mac.mac_rx_data == 8'hff);
    uc_next   = ((byte_num == 11'd1) || uc_ok_q) && (mac.mac_rx_data == mac_byte);

    in_frame    = state_q inside {StDst, StSrc, StType, StPayload};
    start_frame = mac.mac_rx_dvld &&
                  ((state_q == StIdle && !resync_q) || state_q == StWaitStatus);

    // A simultaneous good+bad pulse counts as bad; a filtered frame is dropped silently
    status_seen  = mac.mac_rx_goodframe | mac.mac_rx_badframe;
    good         = mac.mac_rx_goodframe & ~mac.mac_rx_badframe;
    match_now    = good & ~drop_q & (byte_cnt_q >= MinCnt);
    err_now      = ~match_now & ~(good & drop_q);
    status_cycle = ~mac.mac_rx_dvld & status_seen & (in_frame | (state_q == StWaitStatus));
    match_fire   = status_cycle & match_now;

    timer_inc = (timer_q == 32'hffff_ffff) ? timer_q : timer_q + 32'd1;
  end

  assign mac.conf_rx_jumbo_en   = 1'b0;
  assign mac.conf_rx_no_chk_crc = 1'b0;

  always_ff @(posedge not_tx_clk or posedge reset) begin
    if (reset) begin
      state_q        <= StIdle;
      byte_cnt_q     <= '0;
      drop_q         <= 1'b0;
      bc_ok_q        <= 1'b0;
      uc_ok_q        <= 1'b0;
      resync_q       <= 1'b1;
      wait_cnt_q     <= '0;
      armed_q        <= 1'b0;
      timer_q        <= '0;
      frame_match    <= 1'b0;
      frame_err      <= 1'b0;
      delay_count    <= '0;
      delay_valid    <= 1'b0;
      rx_frame_cnt   <= '0;
      mac.conf_rx_en <= 1'b0;
    end else begin
      mac.conf_rx_en <= 1'b1;
      frame_match    <= 1'b0;
      frame_err      <= 1'b0;
      delay_valid    <= 1'b0;
      // After a reset mid-frame, the rest of that frame is skipped until dvld drops
      if (!mac.mac_rx_dvld) resync_q <= 1'b0;

      case (state_q)
        StIdle: ;
        StDst, StSrc, StType, StPayload: begin
          if (!mac.mac_rx_dvld) begin
            if (status_seen) begin
              state_q <= StIdle;
            end else begin
              state_q    <= StWaitStatus;
              wait_cnt_q <= WaitW'(1);
            end
          end else if (byte_cnt_q == MaxCnt) begin
            state_q <= StDrop;
          end else begin
            byte_cnt_q <= byte_num;
            case (state_q)
              StDst: begin
                bc_ok_q <= bc_next;
                uc_ok_q <= uc_next;
                if (byte_num == 11'd6) begin
                  drop_q  <= ~(bc_next | uc_next);
                  state_q <= StSrc;
                end
              end
              StSrc: if (byte_num == 11'd12) state_q <= StType;
              StType: begin
                if (mac.mac_rx_data != type_byte) drop_q <= 1'b1;
                if (byte_num == 11'd14) state_q <= StPayload;
              end
              default: ;
            endcase
          end
        end
        StWaitStatus: begin
          if (mac.mac_rx_dvld) begin
            frame_err <= 1'b1;
          end else if (status_seen) begin
            state_q <= StIdle;
          end else if (wait_cnt_q >= TimeoutCnt) begin
            frame_err <= 1'b1;
            state_q   <= StIdle;
          end else begin
            wait_cnt_q <= wait_cnt_q + WaitW'(1);
          end
        end
        StDrop: begin
          if (!mac.mac_rx_dvld) begin
            frame_err <= 1'b1;
            state_q   <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase

      if (start_frame) begin
        state_q    <= StDst;
        byte_cnt_q <= 11'd1;
        drop_q     <= 1'b0;
        bc_ok_q    <= bc_next;
        uc_ok_q    <= uc_next;
      end

      if (status_cycle) begin
        frame_match <= match_now;
        frame_err   <= err_now;
      end

      if (match_fire) begin
        rx_frame_cnt <= rx_frame_cnt + 16'd1;
        if (armed_q) begin
          delay_count <= timer_inc;
          delay_valid <= 1'b1;
        end
      end

      // Capture above uses the pre-restart count when tx_start coincides with a match
      if (tx_start) begin
        timer_q <= '0;
        armed_q <= 1'b1;
      end else if (match_fire) begin
        armed_q <= 1'b0;
      end else if (armed_q) begin
        timer_q <= timer_inc;
      end
    end
  end

endmodule

// File: tb/tb_frame_receiver.sv
// Directed bench for frame_receiver: hand-built frames and status pulses, counted output pulses
// compared against expected deltas.
`timescale 1ns/1ps
module tb_frame_receiver;
  localparam logic [47:0] MyMac    = 48'h004e46324301;
  localparam logic [47:0] Bcast    = 48'hffffffffffff;
  localparam logic [47:0] OtherMac = 48'h001122334455;
  localparam logic [15:0] Arp      = 16'h0806;
  localparam logic [15:0] Ipv4     = 16'h0800;

  logic        not_tx_clk = 1'b0;
  logic        reset = 1'b0;
  logic        tx_start = 1'b0;
  logic        frame_match;
  logic        frame_err;
  logic        delay_valid;
  logic [31:0] delay_count;
  logic [15:0] rx_frame_cnt;

  frame_receiver_if mac_if ();

  frame_receiver dut (
    .not_tx_clk   (not_tx_clk),
    .reset        (reset),
    .mac          (mac_if),
    .tx_start     (tx_start),
    .frame_match  (frame_match),
    .frame_err    (frame_err),
    .delay_count  (delay_count),
    .delay_valid  (delay_valid),
    .rx_frame_cnt (rx_frame_cnt)
  );

  always #5 not_tx_clk = ~not_tx_clk;

  int cyc = 0;
  int n_match = 0;
  int n_err = 0;
  int n_valid = 0;
  int n_orphan = 0;
  int match_cyc = 0;

  always @(posedge not_tx_clk) cyc <= cyc + 1;

  always @(negedge not_tx_clk) begin
    if (frame_match === 1'b1) begin
      n_match   <= n_match + 1;
      match_cyc <= cyc;
    end
    if (frame_err === 1'b1) n_err <= n_err + 1;
    if (delay_valid === 1'b1) begin
      n_valid <= n_valid + 1;
      if (frame_match !== 1'b1) n_orphan <= n_orphan + 1;
    end
  end

  int n_vec = 0;
  int n_miss = 0;
  int base_m = 0;
  int base_e = 0;
  int t_tx = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge not_tx_clk);
    #1;
  endtask

  function automatic logic [7:0] frame_byte(input logic [47:0] dst, input logic [15:0] et,
                                            input int i);
    if (i <= 6) return dst[8*(6-i) +: 8];
    if (i <= 12) return 8'(16 + i);
    if (i == 13) return et[15:8];
    if (i == 14) return et[7:0];
    return 8'(i);
  endfunction

  task automatic send_frame(input logic [47:0] dst, input logic [15:0] et, input int len);
    for (int i = 1; i <= len; i++) begin
      mac_if.mac_rx_data = frame_byte(dst, et, i);
      mac_if.mac_rx_dvld = 1'b1;
      step(1);
    end
    mac_if.mac_rx_dvld = 1'b0;
    mac_if.mac_rx_data = 8'h00;
  endtask

  task automatic send_status(input logic good, input logic bad, input int gap,
                             input logic with_tx);
    step(gap);
    mac_if.mac_rx_goodframe = good;
    mac_if.mac_rx_badframe  = bad;
    if (with_tx) begin
      tx_start = 1'b1;
      t_tx = cyc + 1;
    end
    step(1);
    mac_if.mac_rx_goodframe = 1'b0;
    mac_if.mac_rx_badframe  = 1'b0;
    tx_start = 1'b0;
  endtask

  task automatic pulse_tx();
    tx_start = 1'b1;
    t_tx = cyc + 1;
    step(1);
    tx_start = 1'b0;
  endtask

  task automatic expect_counts(input string tag, input int dm, input int de);
    step(6);
    check_eq({tag, "/match"}, 32'(n_match - base_m), 32'(dm));
    check_eq({tag, "/err"}, 32'(n_err - base_e), 32'(de));
    base_m = n_match;
    base_e = n_err;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          t1;
    int          t2;
    int          v0;
    logic [31:0] saved_delay;

    mac_if.mac_rx_data      = 8'h00;
    mac_if.mac_rx_dvld      = 1'b0;
    mac_if.mac_rx_goodframe = 1'b0;
    mac_if.mac_rx_badframe  = 1'b0;
    #2 reset = 1'b1;
    #1;
    check_eq("rst/frame_match", 32'(frame_match), 32'd0);
    check_eq("rst/frame_err", 32'(frame_err), 32'd0);
    check_eq("rst/delay_valid", 32'(delay_valid), 32'd0);
    check_eq("rst/delay_count", delay_count, 32'd0);
    check_eq("rst/rx_frame_cnt", 32'(rx_frame_cnt), 32'd0);
    check_eq("rst/conf_rx_en", 32'(mac_if.conf_rx_en), 32'd0);
    step(3);
    reset = 1'b0;
    step(2);
    check_eq("cfg/rx_en", 32'(mac_if.conf_rx_en), 32'd1);
    check_eq("cfg/jumbo", 32'(mac_if.conf_rx_jumbo_en), 32'd0);
    check_eq("cfg/no_chk_crc", 32'(mac_if.conf_rx_no_chk_crc), 32'd0);

    // Broadcast ARP, minimum length
    send_frame(Bcast, Arp, 60);
    send_status(1'b1, 1'b0, 1, 1'b0);
    expect_counts("bcast", 1, 0);
    check_eq("bcast/cnt", 32'(rx_frame_cnt), 32'd1);
    check_eq("bcast/no_valid", 32'(n_valid), 32'd0);

    // Delay measurement over a unicast frame
    pulse_tx();
    t1 = t_tx;
    step(100);
    send_frame(MyMac, Arp, 64);
    send_status(1'b1, 1'b0, 1, 1'b0);
    expect_counts("delay", 1, 0);
    check_eq("delay/valid", 32'(n_valid), 32'd1);
    check_eq("delay/count", delay_count, 32'(match_cyc - t1));
    check_eq("delay/cnt", 32'(rx_frame_cnt), 32'd2);
    saved_delay = delay_count;

    // Filtered frames: silent
    send_frame(OtherMac, Arp, 60);
    send_status(1'b1, 1'b0, 1, 1'b0);
    expect_counts("dst_filter", 0, 0);
    send_frame(Bcast, Ipv4, 60);
    send_status(1'b1, 1'b0, 1, 1'b0);
    expect_counts("type_filter", 0, 0);
    check_eq("filter/cnt", 32'(rx_frame_cnt), 32'd2);

    // Runt and oversize
    send_frame(Bcast, Arp, 40);
    send_status(1'b1, 1'b0, 1, 1'b0);
    expect_counts("runt", 0, 1);
    send_frame(Bcast, Arp, 1600);
    send_status(1'b1, 1'b0, 1, 1'b0);
    expect_counts("oversize", 0, 1);

    // Missing status, then conflicting and bad status
    send_frame(Bcast, Arp, 60);
    step(30);
    expect_counts("timeout", 0, 1);
    send_frame(MyMac, Arp, 60);
    send_status(1'b1, 1'b1, 1, 1'b0);
    expect_counts("good_bad", 0, 1);
    send_frame(MyMac, Arp, 70);
    send_status(1'b0, 1'b1, 2, 1'b0);
    expect_counts("bad", 0, 1);
    check_eq("errs/cnt", 32'(rx_frame_cnt), 32'd2);

    // Back-to-back: second frame starts while the first awaits status
    send_frame(Bcast, Arp, 60);
    step(1);
    send_frame(Bcast, Arp, 60);
    send_status(1'b1, 1'b0, 1, 1'b0);
    expect_counts("b2b", 1, 1);
    check_eq("b2b/cnt", 32'(rx_frame_cnt), 32'd3);
    check_eq("b2b/valid_unarmed", 32'(n_valid), 32'd1);
    check_eq("b2b/delay_kept", delay_count, saved_delay);

    // tx_start on the same edge as the match: old count captured, timer restarted
    v0 = n_valid;
    pulse_tx();
    t1 = t_tx;
    step(20);
    send_frame(Bcast, Arp, 60);
    send_status(1'b1, 1'b0, 1, 1'b1);
    t2 = t_tx;
    expect_counts("coincide1", 1, 0);
    check_eq("coincide1/count", delay_count, 32'(match_cyc - t1));
    send_frame(MyMac, Arp, 80);
    send_status(1'b1, 1'b0, 1, 1'b0);
    expect_counts("coincide2", 1, 0);
    check_eq("coincide2/count", delay_count, 32'(match_cyc - t2));
    check_eq("coincide/valid", 32'(n_valid - v0), 32'd2);

    // Reset at byte 30, rest of frame ignored, then a clean frame
    for (int i = 1; i <= 60; i++) begin
      mac_if.mac_rx_data = frame_byte(Bcast, Arp, i);
      mac_if.mac_rx_dvld = 1'b1;
      if (i == 30) begin
        reset = 1'b1;
        #1;
        check_eq("midrst/rx_frame_cnt", 32'(rx_frame_cnt), 32'd0);
        check_eq("midrst/delay_count", delay_count, 32'd0);
        check_eq("midrst/conf_rx_en", 32'(mac_if.conf_rx_en), 32'd0);
        check_eq("midrst/frame_err", 32'(frame_err), 32'd0);
      end
      if (i == 33) reset = 1'b0;
      step(1);
    end
    mac_if.mac_rx_dvld = 1'b0;
    send_status(1'b1, 1'b0, 1, 1'b0);
    expect_counts("rst_tail", 0, 0);
    check_eq("rst_tail/cnt", 32'(rx_frame_cnt), 32'd0);
    step(2);
    send_frame(Bcast, Arp, 60);
    send_status(1'b1, 1'b0, 1, 1'b0);
    expect_counts("post_rst", 1, 0);
    check_eq("post_rst/cnt", 32'(rx_frame_cnt), 32'd1);

    check_eq("valid_without_match", 32'(n_orphan), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule

// File: doc/frame_receiver.md
FRAME_RECEIVER -- requirements
Module: frame_receiver

Interface
REQ-001 Parameters SHALL be:
- MY_MAC_ADDR, 48'h004e46324301, unicast destination accepted besides broadcast.
- ETH_TYPE_FILTER, 16'h0806, only EtherType accepted.
- MIN_LEN, 60, minimum frame length in bytes (CRC excluded).
- MAX_LEN, 1518, maximum frame length in bytes.
- STATUS_TIMEOUT, 16, cycles allowed for the MAC status pulse after dvld falls.

REQ-002 Ports SHALL be (name, direction, width, meaning):
- not_tx_clk, in, 1, clock; all logic on its rising edge.
- reset, in, 1, asynchronous, active-high.
- conf_rx_en, out, 1, MAC receive enable.
- conf_rx_jumbo_en, out, 1, MAC jumbo enable.
- conf_rx_no_chk_crc, out, 1, MAC CRC-check disable.
- mac_rx_data, in, 8, receive byte, valid while mac_rx_dvld=1.
- mac_rx_dvld, in, 1, high for every byte of a frame, contiguous.
- mac_rx_goodframe, in, 1, one-cycle pulse, frame CRC good.
- mac_rx_badframe, in, 1, one-cycle pulse, frame CRC bad.
- tx_start, in, 1, one-cycle pulse, local sender started a frame.
- frame_match, out, 1, one-cycle pulse, accepted frame completed good.
- frame_err, out, 1, one-cycle pulse, frame rejected for an error.
- delay_count, out, 32, latched cycles from tx_start to frame_match.
- delay_valid, out, 1, one-cycle pulse coincident with delay_count update.
- rx_frame_cnt, out, 16, count of frame_match pulses, wraps at 16'hFFFF.

Function
REQ-003 States SHALL be IDLE, DST, SRC, TYPE, PAYLOAD, WAIT_STATUS, DROP; 11-bit byte counter byte_cnt counts bytes of the current frame, starting at 1.
REQ-004 IDLE: on mac_rx_dvld=1 capture byte 1, go to DST; otherwise stay.
REQ-005 DST (bytes 1-6, MSB first): mismatch against both 48'hFFFFFFFFFFFF and MY_MAC_ADDR SHALL set a drop flag; after byte 6 go to SRC.
REQ-006 SRC (bytes 7-12): bytes are ignored; after byte 12 go to TYPE.
REQ-007 TYPE (bytes 13-14): mismatch against ETH_TYPE_FILTER SHALL set the drop flag; then go to PAYLOAD.
REQ-008 In any state except IDLE/WAIT_STATUS, dvld falling SHALL go to WAIT_STATUS with the final length latched.
REQ-009 If byte_cnt would exceed MAX_LEN, go to DROP; frame_err pulses when dvld falls; then go to IDLE, ignoring status pulses.
REQ-010 WAIT_STATUS waits up to STATUS_TIMEOUT cycles; on goodframe with no drop flag and length >= MIN_LEN: frame_match=1, rx_frame_cnt+1; on goodframe with drop flag: no pulse (silent filter); on badframe, runt (<MIN_LEN) or timeout: frame_err=1; always return to IDLE next cycle.
REQ-011 goodframe and badframe in the same cycle SHALL be treated as badframe.
REQ-012 dvld=1 while in WAIT_STATUS (back-to-back frame) SHALL abandon the pending frame with frame_err=1 and start DST with that byte as byte 1.
REQ-013 Delay timer: tx_start SHALL clear a 32-bit running counter to 0 and arm it; armed counter increments each cycle, saturating at 32'hFFFFFFFF.
REQ-014 On frame_match while armed: delay_count <= counter value, delay_valid=1 same cycle, timer disarmed; frame_match while unarmed SHALL not touch delay_count or delay_valid.
REQ-015 tx_start coincident with frame_match: delay captured from the old count first, then counter restarts at 0 armed.
REQ-016 Config outputs: conf_rx_en=1 from the first clock after reset deasserts; conf_rx_jumbo_en=0, conf_rx_no_chk_crc=0 always.
REQ-017 All outputs SHALL be registered; frame_match/frame_err appear the cycle after the qualifying status pulse.

Reset
REQ-018 Asserting reset SHALL asynchronously force: state IDLE, byte_cnt 0, drop flag 0, timer disarmed and 0, all outputs 0 (delay_count 0, rx_frame_cnt 0, conf_rx_en 0).
REQ-019 Reset mid-frame SHALL discard the frame; after release, bytes of the remaining frame are ignored until dvld is low for at least one cycle.

Verification
REQ-020 Broadcast ARP 60-byte frame, goodframe 2 cycles after dvld falls -> one frame_match, rx_frame_cnt=1, no frame_err.
REQ-021 tx_start, then 100 cycles later accepted frame completes with goodframe -> delay_valid=1, delay_count equals cycles between tx_start and the frame_match cycle (exact per REQ-013/014).
REQ-022 Destination 48'h001122334455 or EtherType 16'h0800, goodframe -> no frame_match, no frame_err, counters unchanged.
REQ-023 40-byte ARP frame with goodframe -> frame_err=1; 1600-byte frame -> DROP, single frame_err, status ignored.
REQ-024 Valid frame, no status pulse within 16 cycles -> frame_err=1, return to IDLE; goodframe+badframe together -> frame_err.
REQ-025 Reset asserted at byte 30 -> all outputs 0 immediately; next complete valid frame -> frame_match, rx_frame_cnt=1.
